f1_start_lights: RTL and testbench
==================================

F1_START_LIGHTS -- requirements
Module: f1_start_lights

Interface
REQ-001 SHALL have parameter N_LIGHTS, default 8, number of lights in data_out (2..16).
REQ-002 SHALL have parameter TICK_W, default 16, width of tick divisor n.
REQ-003 SHALL have parameter LFSR_W, default 7, width of hold-delay LFSR; LFSR_SEED, default 1, nonzero reset value.
REQ-004 SHALL have parameter RT_W, default 16, width of reaction-time counter.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: trigger  in  1  start request; press  in  1  driver button; n  in  TICK_W  tick period minus one.
REQ-007 SHALL have ports: data_out  out  N_LIGHTS  light pattern; busy  out  1  high in FILL/HOLD/OUT.
REQ-008 SHALL have ports: react_valid  out  1  result held; react_time  out  RT_W  cycles from lights-out to press; jump_start  out  1  fault flag.

Function
REQ-009 SHALL implement states IDLE, FILL, HOLD, OUT, DONE, FAULT.
REQ-010 Tick SHALL pulse once every n+1 cycles; tick counter SHALL clear on every state change; n=0 SHALL give a tick every cycle.
REQ-011 IDLE: trigger=1 -> FILL next cycle, data_out=0.
REQ-012 FILL: each tick shifts data_out left and inserts 1; tick with data_out all-ones -> HOLD, hold_cnt loaded with current LFSR value.
REQ-013 HOLD: each tick decrements hold_cnt; tick with hold_cnt==1 -> OUT, data_out=0, reaction counter cleared.
REQ-014 OUT: reaction counter increments every cycle and saturates at 2^RT_W-1; press=1 -> DONE, react_time latched, react_valid=1.
REQ-015 press=1 in FILL or HOLD -> FAULT, jump_start=1, data_out all-ones; press takes priority over a same-cycle tick transition.
REQ-016 FAULT: data_out SHALL toggle between all-ones and all-zeros on each tick.
REQ-017 DONE or FAULT: trigger=1 -> FILL, clearing react_valid and jump_start; react_time SHALL hold until the next DONE.
REQ-018 trigger SHALL be ignored in FILL, HOLD and OUT; press SHALL be ignored in IDLE, DONE and FAULT.
REQ-019 LFSR SHALL be Fibonacci, maximal-length for LFSR_W, advancing every cycle, never zero; hold delay range SHALL be 1..2^LFSR_W-1 ticks.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 rst=1 SHALL force IDLE, data_out=0, busy=0, react_valid=0, react_time=0, jump_start=0, LFSR=LFSR_SEED, all counters 0.
REQ-022 rst SHALL take priority over all inputs, including mid-sequence in any state.

Structure
REQ-023 State enum and LFSR tap table SHALL reside in package f1_pkg.
REQ-024 LFSR SHALL be sub-module lfsr_gen (params WIDTH, SEED; ports clk, rst, q).
REQ-025 Tick generator, hold counter and reaction counter SHALL be inline.

Verification
REQ-026 N_LIGHTS=8, n=0, trigger 1 cycle -> data_out 0x01,0x03,...,0xFF on consecutive cycles, then HOLD with busy=1.
REQ-027 n=3 -> each FILL step spaced exactly 4 cycles; HOLD length equals loaded LFSR value x 4 cycles.
REQ-028 press 25 cycles after data_out goes to 0 -> react_time=25, react_valid=1 until next trigger.
REQ-029 press during HOLD -> jump_start=1, data_out alternating 0xFF/0x00 per tick; trigger -> FILL, jump_start=0.
REQ-030 RT_W=4, no press for 20 cycles in OUT -> counter saturates at 15; then press -> react_time=15.
REQ-031 rst asserted mid-HOLD -> next cycle IDLE, all outputs 0, LFSR=LFSR_SEED.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types for the F1 start-lights block: controller states and the
// maximal-length LFSR tap table.
package f1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_HOLD,
        ST_OUT,
        ST_DONE,
        ST_FAULT
    } state_e;

    // Fibonacci tap masks (bit i set = stage i+1 feeds the XOR), widths 2..16
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            2:       taps = 16'h0003;
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR; advances every cycle and never reaches zero
// from a nonzero seed.
module lfsr_gen
    import f1_pkg::*;
#(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= SEED;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/f1_start_lights.sv
// F1 start-light sequencer: lights fill one per tick, hold for a random
// number of ticks, go out, then time the driver's reaction or flag a jump start.
module f1_start_lights
    import f1_pkg::*;
#(
    parameter int                N_LIGHTS  = 8,
    parameter int                TICK_W    = 16,
    parameter int                LFSR_W    = 7,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1),
    parameter int                RT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic                press,
    input  logic [TICK_W-1:0]   n,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                busy,
    output logic                react_valid,
    output logic [RT_W-1:0]     react_time,
    output logic                jump_start
);

    localparam logic [N_LIGHTS-1:0] ALL_ON = '1;
    localparam logic [RT_W-1:0]     RT_MAX = '1;

    state_e              state_d, state_q;
    logic [TICK_W-1:0]   tick_cnt_d, tick_cnt_q;
    logic [LFSR_W-1:0]   hold_cnt_d, hold_cnt_q;
    logic [RT_W-1:0]     react_cnt_d, react_cnt_q;
    logic [N_LIGHTS-1:0] data_out_d, data_out_q;
    logic                busy_d, busy_q;
    logic                react_valid_d, react_valid_q;
    logic [RT_W-1:0]     react_time_d, react_time_q;
    logic                jump_start_d, jump_start_q;
    logic [LFSR_W-1:0]   lfsr_q;
    logic                tick;

    lfsr_gen #(
        .WIDTH (LFSR_W),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    always_comb begin
        // >= rather than == so a lowered n mid-count cannot stall the divider
        tick          = (tick_cnt_q >= n);
        state_d       = state_q;
        data_out_d    = data_out_q;
        hold_cnt_d    = hold_cnt_q;
        react_cnt_d   = react_cnt_q;
        react_valid_d = react_valid_q;
        react_time_d  = react_time_q;
        jump_start_d  = jump_start_q;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d    = ST_FILL;
                    data_out_d = '0;
                end
            end
            ST_FILL: begin
                if (press) begin
                    state_d      = ST_FAULT;
                    data_out_d   = ALL_ON;
                    jump_start_d = 1'b1;
                end else if (tick) begin
                    if (data_out_q == ALL_ON) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = lfsr_q;
                    end else begin
                        data_out_d = {data_out_q[N_LIGHTS-2:0], 1'b1};
                    end
                end
            end
            ST_HOLD: begin
                if (press) begin
                    state_d      = ST_FAULT;
                    data_out_d   = ALL_ON;
                    jump_start_d = 1'b1;
                end else if (tick) begin
                    if (hold_cnt_q == LFSR_W'(1)) begin
                        state_d     = ST_OUT;
                        data_out_d  = '0;
                        react_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                    end
                end
            end
            ST_OUT: begin
                // the press cycle itself counts, so a press N edges after
                // lights-out latches N
                react_cnt_d = (react_cnt_q == RT_MAX) ? RT_MAX : react_cnt_q + 1'b1;
                if (press) begin
                    state_d       = ST_DONE;
                    react_time_d  = react_cnt_d;
                    react_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (trigger) begin
                    state_d       = ST_FILL;
                    data_out_d    = '0;
                    react_valid_d = 1'b0;
                    jump_start_d  = 1'b0;
                end
            end
            ST_FAULT: begin
                if (trigger) begin
                    state_d       = ST_FILL;
                    data_out_d    = '0;
                    react_valid_d = 1'b0;
                    jump_start_d  = 1'b0;
                end else if (tick) begin
                    data_out_d = ~data_out_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tick_cnt_d = (state_d != state_q || tick) ? '0 : tick_cnt_q + 1'b1;
        busy_d     = (state_d inside {ST_FILL, ST_HOLD, ST_OUT});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tick_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            react_cnt_q   <= '0;
            data_out_q    <= '0;
            busy_q        <= 1'b0;
            react_valid_q <= 1'b0;
            react_time_q  <= '0;
            jump_start_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            react_cnt_q   <= react_cnt_d;
            data_out_q    <= data_out_d;
            busy_q        <= busy_d;
            react_valid_q <= react_valid_d;
            react_time_q  <= react_time_d;
            jump_start_q  <= jump_start_d;
        end
    end

    assign data_out    = data_out_q;
    assign busy        = busy_q;
    assign react_valid = react_valid_q;
    assign react_time  = react_time_q;
    assign jump_start  = jump_start_q;

endmodule

// File: tb/tb_f1_start_lights.sv
// Bench for f1_start_lights: directed vector table, hand-built timing
// sequences and a long random run against a behavioural model.
module tb_f1_start_lights;

    localparam int NL = 8;
    localparam int TW = 16;
    localparam int LW = 7;
    localparam int RW = 16;

    localparam int P_IDLE  = 0;
    localparam int P_FILL  = 1;
    localparam int P_HOLD  = 2;
    localparam int P_OUT   = 3;
    localparam int P_DONE  = 4;
    localparam int P_FAULT = 5;

    logic          clk = 1'b0;
    logic          rst, trigger, press;
    logic [TW-1:0] n;
    logic [NL-1:0] data_out, data_out4;
    logic          busy, busy4, rv, rv4, js, js4;
    logic [RW-1:0] rt;
    logic [3:0]    rt4;

    f1_start_lights #(.N_LIGHTS(NL), .TICK_W(TW), .LFSR_W(LW), .RT_W(RW)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .press(press), .n(n),
        .data_out(data_out), .busy(busy), .react_valid(rv), .react_time(rt), .jump_start(js)
    );

    f1_start_lights #(.N_LIGHTS(NL), .TICK_W(TW), .LFSR_W(LW), .RT_W(4)) dut4 (
        .clk(clk), .rst(rst), .trigger(trigger), .press(press), .n(n),
        .data_out(data_out4), .busy(busy4), .react_valid(rv4), .react_time(rt4), .jump_start(js4)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // behavioural model: lit-lamp count, ticks left, cycles since lights out
    int m_phase, m_lit, m_since, m_hold, m_hold_loaded, m_react, m_rt, m_lfsr;
    bit m_flash, m_valid, m_jump;

    function automatic void model_reset();
        m_phase = P_IDLE; m_lit = 0; m_since = 0; m_hold = 0; m_hold_loaded = 0;
        m_react = 0; m_rt = 0; m_flash = 0; m_valid = 0; m_jump = 0;
        m_lfsr  = 1;
    endfunction

    // x^7 + x^6 + 1, new bit enters at the bottom
    function automatic int lfsr_next(input int v);
        return ((v << 1) | (((v >> 6) ^ (v >> 5)) & 1)) & 127;
    endfunction

    task automatic model_step(input bit r, input bit t, input bit p, input int nn);
        int prev;
        bit tk;
        if (r) begin
            model_reset();
            return;
        end
        prev = m_phase;
        tk   = ((m_since % (nn + 1)) == nn);
        case (m_phase)
            P_IDLE: if (t) begin m_phase = P_FILL; m_lit = 0; end
            P_FILL, P_HOLD: begin
                if (p) begin
                    m_phase = P_FAULT; m_flash = 1; m_jump = 1;
                end else if (tk && m_phase == P_FILL) begin
                    if (m_lit == NL) begin
                        m_phase = P_HOLD; m_hold = m_lfsr; m_hold_loaded = m_lfsr;
                    end else m_lit++;
                end else if (tk) begin
                    if (m_hold == 1) begin m_phase = P_OUT; m_react = 0; end
                    else m_hold--;
                end
            end
            P_OUT: begin
                m_react++;
                if (p) begin m_phase = P_DONE; m_rt = m_react; m_valid = 1; end
            end
            default: begin
                if (t) begin
                    m_phase = P_FILL; m_lit = 0; m_valid = 0; m_jump = 0;
                end else if (m_phase == P_FAULT && tk) m_flash = ~m_flash;
            end
        endcase
        m_since = (m_phase != prev) ? 0 : m_since + 1;
        m_lfsr  = lfsr_next(m_lfsr);
    endtask

    function automatic int exp_data();
        case (m_phase)
            P_FILL:  return (1 << m_lit) - 1;
            P_HOLD:  return 255;
            P_FAULT: return m_flash ? 255 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic compare_model();
        bit eb;
        eb = (m_phase == P_FILL || m_phase == P_HOLD || m_phase == P_OUT);
        check("data_out", data_out, exp_data());
        check("busy", busy, eb);
        check("react_valid", rv, m_valid);
        check("jump_start", js, m_jump);
        check("react_time", rt, (m_rt > 65535) ? 65535 : m_rt);
        check("data_out_rt4", data_out4, exp_data());
        check("busy_rt4", busy4, eb);
        check("react_valid_rt4", rv4, m_valid);
        check("jump_start_rt4", js4, m_jump);
        check("react_time_rt4", rt4, (m_rt > 15) ? 15 : m_rt);
    endtask

    task automatic cyc(input bit r, input bit t, input bit p);
        rst = r; trigger = t; press = p;
        @(posedge clk);
        model_step(r, t, p, int'(n));
        #1;
        compare_model();
    endtask

    typedef struct {
        bit         r, t, p;
        logic [7:0] d;
        bit         b, v, j;
    } vec_t;

    vec_t tbl [0:16];

    initial begin
        int c;
        logic [NL-1:0] prev;
        rst = 1'b1; trigger = 1'b0; press = 1'b0; n = '0;
        model_reset();

        // n = 0: fill one lamp per cycle, HOLD, jump start, flash, restart
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h1F, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h3F, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i <= 16; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].p);
            check($sformatf("tbl%0d_data", i), data_out, tbl[i].d);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
            check($sformatf("tbl%0d_valid", i), rv, tbl[i].v);
            check($sformatf("tbl%0d_jump", i), js, tbl[i].j);
            check($sformatf("tbl%0d_rtime", i), rt, 0);
        end

        // n = 3: four cycles per lamp, HOLD lasts loaded-value * 4 cycles
        n = 16'd3;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        for (int s = 0; s < NL; s++) begin
            prev = data_out;
            c = 0;
            do begin cyc(1'b0, 1'b0, 1'b0); c++; end while (data_out == prev && c < 20);
            check($sformatf("fill_gap%0d", s), c, 4);
        end
        c = 0;
        do begin cyc(1'b0, 1'b0, 1'b0); c++; end while (data_out != 0 && c < 1200);
        check("hold_len", c, 4 + 4 * m_hold_loaded);
        check("out_busy", busy, 1);

        // press 25 cycles after lights out; RT_W=4 copy saturates at 15
        for (int k = 0; k < 24; k++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check("react_25", rt, 25);
        check("react_sat15", rt4, 15);
        check("react_valid_set", rv, 1);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1);
        check("react_valid_hold", rv, 1);
        check("react_25_hold", rt, 25);
        cyc(1'b0, 1'b1, 1'b0);
        check("react_valid_clr", rv, 0);
        check("react_time_kept", rt, 25);

        // reset in the middle of HOLD
        n = '0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        c = 0;
        do begin cyc(1'b0, 1'b0, 1'b0); c++; end while (data_out != 8'hFF && c < 20);
        cyc(1'b0, 1'b0, 1'b0);
        check("midhold_busy", busy, 1);
        cyc(1'b1, 1'b0, 1'b0);
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", rv, 0);
        check("rst_rtime", rt, 0);
        check("rst_jump", js, 0);
        check("rst_lfsr_seed", dut.lfsr_q, 1);

        // random run against the model
        n = 16'($urandom_range(0, 3));
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4000; k++) begin
            bit r, t, p;
            r = ($urandom_range(0, 299) == 0);
            t = ($urandom_range(0, 7) == 0);
            p = (m_phase == P_OUT) ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 119) == 0);
            if ((m_phase == P_IDLE || m_phase == P_DONE || m_phase == P_OUT) && $urandom_range(0, 39) == 0)
                n = 16'($urandom_range(0, 3));
            cyc(r, t, p);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
